// File: rtl/argunda_sar_ctrl.sv
// argunda_sar_ctrl: successive-approximation controller driving an off-chip R-2R DAC code and a S/H enable.
// Latency: start seen in IDLE at cycle 0 -> result_valid at cycle SAMPLE_CYCLES+NBITS*SETTLE_CYCLES+1.
// No backpressure: start is ignored while busy; optional macro SAR_AVG4_EN reports the mean of 4 conversions.
module argunda_sar_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             cmp_in_i,
  output logic             sample_en_o,
  output logic [NBITS-1:0] dac_code_o,
  output logic             busy_o,
  output logic [NBITS-1:0] result_o,
  output logic             result_valid_o
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = $clog2(NBITS);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] BIT_TOP     = IW'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] res_q, res_d;
  logic             rv_q, rv_d;
  logic             cmp_meta_q, cmp_s_q;
  logic [NBITS-1:0] code_fin;

`ifdef SAR_AVG4_EN
  logic [NBITS+1:0] acc_q, acc_d;
  logic [NBITS+1:0] acc_sum;
  logic [1:0]       avg_cnt_q, avg_cnt_d;
`endif

  // Two-flop synchronizer: the comparator is asynchronous to clk and never used raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_in_i;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= BIT_TOP;
      dac_q     <= '0;
      res_q     <= '0;
      rv_q      <= 1'b0;
`ifdef SAR_AVG4_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      dac_q     <= dac_d;
      res_q     <= res_d;
      rv_q      <= rv_d;
`ifdef SAR_AVG4_EN
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
`endif
    end
  end

  // Next-state logic: sample window, per-bit trial/decide, result publication.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    dac_d    = dac_q;
    res_d    = res_q;
    rv_d     = 1'b0;
    code_fin = dac_q;
    code_fin[bit_q] = cmp_s_q;
`ifdef SAR_AVG4_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + {2'b00, code_fin};
`endif

    case (state_q)
      S_IDLE: begin
        dac_d = '0;
        cnt_d = '0;
        bit_d = BIT_TOP;
        if (start_i) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        dac_d = '0;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          bit_d   = BIT_TOP;
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONVERT: begin
        if (cnt_q == SETTLE_LAST) begin
          // Decide this bit from the synchronized comparator level.
          dac_d = code_fin;
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = S_DONE;
`ifdef SAR_AVG4_EN
            if (avg_cnt_q == 2'd3) begin
              res_d     = acc_sum[NBITS+1:2];
              rv_d      = 1'b1;
              acc_d     = '0;
              avg_cnt_d = '0;
            end else begin
              acc_d     = acc_sum;
              avg_cnt_d = avg_cnt_q + 2'd1;
            end
`else
            res_d = code_fin;
            rv_d  = 1'b1;
`endif
          end else begin
            bit_d = bit_q - IW'(1);
          end
        end else begin
          if (cnt_q == '0) dac_d[bit_q] = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        dac_d = '0;
        cnt_d = '0;
        bit_d = BIT_TOP;
`ifdef SAR_AVG4_EN
        // Intermediate conversions of an average always continue.
        if (!rv_q || cont_i) state_d = S_SAMPLE;
        else                 state_d = S_IDLE;
`else
        if (cont_i) state_d = S_SAMPLE;
        else        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Disable wins everywhere: abort, discard the partial code, keep the old result.
    if (!ena_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = BIT_TOP;
      dac_d   = '0;
      res_d   = res_q;
      rv_d    = 1'b0;
`ifdef SAR_AVG4_EN
      acc_d     = '0;
      avg_cnt_d = '0;
`endif
    end
  end

  assign sample_en_o    = (state_q == S_SAMPLE);
  assign busy_o         = (state_q != S_IDLE);
  assign dac_code_o     = dac_q;
  assign result_o       = res_q;
  assign result_valid_o = rv_q;

endmodule

// File: tb/tb_argunda_sar_ctrl.sv
// Testbench for argunda_sar_ctrl: ideal comparator (cmp_in = vin >= dac_code), scoreboard on result_valid,
// directed cases for timing/abort/reset plus random input codes. The expected SAR result for an ideal
// comparator is the input code itself; trial codes are vin's already-decided upper bits plus the trial bit.
module tb_argunda_sar_ctrl;

  localparam int NB  = 8;
  localparam int LAT = 16 + NB * 4 + 1;

  typedef struct {
    logic [NB-1:0] val;
    int unsigned   due;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          start;
  logic          cont;
  logic          cmp_in;
  logic          sample_en;
  logic [NB-1:0] dac_code;
  logic          busy;
  logic [NB-1:0] result;
  logic          result_valid;

  logic [NB-1:0] vin;
  logic [NB-1:0] last_res;
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];

  argunda_sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(16), .SETTLE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena_i          (ena),
    .start_i        (start),
    .cont_i         (cont),
    .cmp_in_i       (cmp_in),
    .sample_en_o    (sample_en),
    .dac_code_o     (dac_code),
    .busy_o         (busy),
    .result_o       (result),
    .result_valid_o (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign cmp_in = (vin >= dac_code);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [NB-1:0] v, input int unsigned due);
    exp_t e;
    e.val = v;
    e.due = due;
    exp_q.push_back(e);
  endtask

  // Monitor: every result_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e.val);
          chk("result_valid_cycle", cyc, e.due);
        end
      end
    end
  end

  // One conversion from IDLE with full timing checks; optional second start pulse mid-conversion.
  task automatic run_conv(input logic [NB-1:0] v, input bit chk_tr, input int pulse_at);
    int unsigned   c;
    int            se_cnt;
    int            i;
    logic [NB-1:0] trial;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    c     = cyc;
    push_exp(v, c + LAT);
    se_cnt = 0;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        chk("busy_rise", busy, 1'b1);
      end
      if (pulse_at != 0 && n == pulse_at)     start = 1'b1;
      if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
      if (sample_en) se_cnt++;
      if (chk_tr && n >= 18 && n <= 18 + 4 * (NB - 1) && ((n - 18) % 4) == 0) begin
        i     = NB - 1 - (n - 18) / 4;
        trial = ((v >> (i + 1)) << (i + 1)) | (NB'(1) << i);
        chk("dac_trial", dac_code, trial);
      end
      if (n == LAT + 1) chk("busy_fall", busy, 1'b0);
    end
    chk("sample_en_cycles", se_cnt, 16);
    last_res = v;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    vin   = '0;
    last_res = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_sample_en", sample_en, 1'b0);
    chk("rst_dac_code", dac_code, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

`ifdef SAR_AVG4_EN
    // Four conversions averaged into one result.
    @(negedge clk);
    vin   = 8'd10;
    start = 1'b1;
    c     = cyc;
    push_exp(8'((10 + 11 + 12 + 14) >> 2), c + 4 * LAT);
    for (int n = 1; n <= 4 * LAT + 1; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == LAT + 1)     vin = 8'd11;
      if (n == 2 * LAT + 1) vin = 8'd12;
      if (n == 3 * LAT + 1) vin = 8'd14;
      if (n == 2 * LAT) chk("avg_busy_mid", busy, 1'b1);
      if (n == 4 * LAT + 1) chk("avg_busy_fall", busy, 1'b0);
    end
`else
    // Basic conversion with trial sequence, then full-scale limits.
    run_conv(8'hA5, 1'b1, 0);
    run_conv(8'hFF, 1'b1, 0);
    run_conv(8'h00, 1'b1, 0);

    // Continuous mode: back-to-back results, cont dropped during the second.
    @(negedge clk);
    vin   = 8'h10;
    cont  = 1'b1;
    start = 1'b1;
    c     = cyc;
    push_exp(8'h10, c + LAT);
    push_exp(8'h7E, c + 2 * LAT);
    for (int n = 1; n <= 2 * LAT + 1; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == LAT + 1) begin
        vin = 8'h7E;
        chk("cont_no_gap", busy, 1'b1);
      end
      if (n == LAT + 11) cont = 1'b0;
      if (n == 2 * LAT + 1) chk("cont_stop_idle", busy, 1'b0);
    end
    last_res = 8'h7E;

    // Start pulsed mid-conversion is ignored.
    run_conv(8'h5C, 1'b0, 20);
    repeat (10) @(negedge clk);
    chk("restart_ignored_idle", busy, 1'b0);

    // Enable dropped mid-conversion: abort, result retained, no pulse.
    @(negedge clk);
    vin   = 8'h3C;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 30) ena = 1'b0;
      if (n == 31) begin
        chk("ena_busy", busy, 1'b0);
        chk("ena_dac", dac_code, 0);
        chk("ena_sample_en", sample_en, 1'b0);
        chk("ena_result_held", result, last_res);
      end
      if (n == 35) ena = 1'b1;
      if (n == 40) chk("ena_stay_idle", busy, 1'b0);
    end

    // Reset in the middle of CONVERT clears everything asynchronously.
    @(negedge clk);
    vin   = 8'h5A;
    start = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_dac", dac_code, 0);
    chk("arst_sample_en", sample_en, 1'b0);
    chk("arst_result", result, 0);
    chk("arst_result_valid", result_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;

    // Random input codes.
    for (int k = 0; k < 8; k++) begin
      run_conv(NB'($urandom_range(0, 255)), 1'b1, 0);
    end
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
